// File: rtl/sccb_target.sv
// SCCB/I2C target with an 8-bit sub-address register port.
// SCL/SDA are oversampled in the clk domain; SDA is driven open-drain for ACK and read data.
module sccb_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVA,
    S_DEVA_ACK,
    S_SUBA,
    S_SUBA_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [6:0]       rx_q;
  logic [7:0]       tx_q;
  logic             rw_q;
  logic             ack_phase_q;
  logic             sda_oe_q;
  logic [7:0]       reg_addr_q;
  logic [7:0]       reg_wdata_q;
  logic             reg_we_q;
  logic             reg_re_q;
  logic             busy_q;
  logic [7:0]       rx_byte;

  // Input synchronizers plus one delay stage; idle bus is high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign rx_byte   = {rx_q, sda_s};

  // Protocol FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      if (reg_re_q) begin
        tx_q <= reg_rdata;
      end
      // Post-write pointer advance, one clk after the strobe used the old pointer.
      if (reg_we_q) begin
        reg_addr_q <= reg_addr_q + 8'd1;
      end

      if (start_det) begin
        state_q     <= S_DEVA;
        bit_cnt_q   <= '0;
        sda_oe_q    <= 1'b0;
        ack_phase_q <= 1'b0;
        busy_q      <= 1'b1;
      end else if (stop_det) begin
        state_q     <= S_IDLE;
        bit_cnt_q   <= '0;
        sda_oe_q    <= 1'b0;
        ack_phase_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_DEVA, S_SUBA, S_WDATA: begin
            if (scl_rise) begin
              rx_q      <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(7)) begin
                bit_cnt_q <= '0;
                if (state_q == S_DEVA) begin
                  if (rx_byte[7:1] != DEV_ADDR) begin
                    state_q <= S_IGNORE;
                  end else begin
                    state_q  <= S_DEVA_ACK;
                    rw_q     <= rx_byte[0];
                    reg_re_q <= rx_byte[0];
                  end
                end else if (state_q == S_SUBA) begin
                  reg_addr_q <= rx_byte;
                  state_q    <= S_SUBA_ACK;
                end else begin
                  reg_wdata_q <= rx_byte;
                  reg_we_q    <= 1'b1;
                  state_q     <= S_WDATA_ACK;
                end
              end
            end
          end

          // Target ACK slot: pull low on the fall after bit 8, release on the next fall.
          S_DEVA_ACK, S_SUBA_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                sda_oe_q    <= 1'b0;
                if (state_q == S_DEVA_ACK) begin
                  if (rw_q) begin
                    sda_oe_q <= ~tx_q[7];
                    tx_q     <= {tx_q[6:0], 1'b0};
                    state_q  <= S_RDATA;
                  end else begin
                    state_q <= S_SUBA;
                  end
                end else begin
                  state_q <= S_WDATA;
                end
              end
            end
          end

          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == CNT_W'(7)) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= S_RDATA_ACK;
              end else begin
                sda_oe_q  <= ~tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end

          // Master ACK slot: ACK fetches the next pointer, NACK ends the read.
          S_RDATA_ACK: begin
            if (scl_rise && !ack_phase_q) begin
              reg_addr_q <= reg_addr_q + 8'd1;
              if (sda_s) begin
                state_q <= S_IGNORE;
              end else begin
                reg_re_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end
            end else if (scl_fall && ack_phase_q) begin
              ack_phase_q <= 1'b0;
              bit_cnt_q   <= '0;
              sda_oe_q    <= ~tx_q[7];
              tx_q        <= {tx_q[6:0], 1'b0};
              state_q     <= S_RDATA;
            end
          end

          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bus-master tasks, behavioural register model and strobe scoreboard.
module tb_sccb_target;

  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] rf  [256];
  logic [7:0] mdl [256];
  logic [7:0] ptr;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_t        mon_w;
  logic [7:0] mon_a;
  int         checks = 0;
  int         errors = 0;
  bit         oe_seen = 1'b0;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = rf[reg_addr];

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_wdata;

  sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops its expected entry from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_we && reg_re) chk("we_re_exclusive", 1, 0);
      if (reg_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_we: addr %0h data %0h, expected no write", reg_addr, reg_wdata);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("we_addr", reg_addr, mon_w.a);
          chk("we_data", reg_wdata, mon_w.d);
        end
      end
      if (reg_re) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_re: addr %0h, expected no read", reg_addr);
        end else begin
          mon_a = exp_rd.pop_front();
          chk("re_addr", reg_addr, mon_a);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
    end
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic put_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  // Write transaction: device address, sub-address, n data bytes from word.
  task automatic wr_txn(input logic [7:0] sub, input logic [31:0] word, input int n, input bit do_stop);
    logic ack;
    logic [7:0] d;
    bus_start();
    chk("busy_after_start", busy, 1);
    put_byte(8'h42, ack); chk("deva_ack", ack, 0);
    put_byte(sub, ack);   chk("suba_ack", ack, 0);
    ptr = sub;
    for (int i = 0; i < n; i++) begin
      d = word[8*i +: 8];
      exp_wr.push_back('{a: ptr, d: d});
      mdl[ptr] = d;
      put_byte(d, ack); chk("wdata_ack", ack, 0);
      ptr = ptr + 8'd1;
    end
    if (do_stop) begin
      bus_stop();
      chk("busy_after_stop", busy, 0);
      chk("oe_after_stop", sda_oe, 0);
      chk("addr_after_write", reg_addr, ptr);
    end
  endtask

  // Read transaction: n bytes, master ACKs all but the last, then STOP.
  task automatic rd_txn(input int n);
    logic ack;
    logic b;
    logic [7:0] byte_v;
    bus_start();
    exp_rd.push_back(ptr);
    put_byte(8'h43, ack); chk("rdev_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      for (int j = 7; j >= 0; j--) begin
        get_bit(b);
        byte_v[j] = b;
      end
      chk("rdata", byte_v, mdl[ptr]);
      ptr = ptr + 8'd1;
      if (k != n - 1) exp_rd.push_back(ptr);
      put_bit(k == n - 1);
    end
    bus_stop();
    chk("busy_after_rd", busy, 0);
    chk("oe_after_rd", sda_oe, 0);
    chk("addr_after_rd", reg_addr, ptr);
  endtask

  initial begin
    logic ack;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      rf[i] = v;
      mdl[i] = v;
    end
    rf[8'h0A] = 8'h76;
    mdl[8'h0A] = 8'h76;
    ptr = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst_n = 1'b1;
    wait_q();

    // T1 single write
    wr_txn(8'h12, 32'h80, 1, 1'b1);

    // T2 set pointer then read 0x76
    wr_txn(8'h0A, 32'h0, 0, 1'b1);
    rd_txn(1);

    // T3 wrong device address: no ACK, no strobes
    oe_seen = 1'b0;
    bus_start();
    put_byte(8'h44, ack); chk("mismatch_ack0", ack, 1);
    put_byte(8'h12, ack); chk("mismatch_ack1", ack, 1);
    put_byte(8'h55, ack); chk("mismatch_ack2", ack, 1);
    bus_stop();
    chk("mismatch_oe_seen", oe_seen, 0);
    chk("mismatch_addr", reg_addr, ptr);

    // T4 burst with pointer wrap
    wr_txn(8'hFE, 32'h00C3B2A1, 3, 1'b1);
    chk("wrap_addr", reg_addr, 8'h01);

    // T5 repeated START into a two-byte read
    wr_txn(8'h20, 32'h0, 0, 1'b0);
    rd_txn(2);

    // T6 reset during the 5th bit of a data byte
    wr_txn(8'h12, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(i[0]);
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", reg_addr, 0);
    scl = 1'b0; wait_q();
    rst_n = 1'b1; wait_q();
    bus_stop();
    ptr = 8'h00;
    chk("postrst_busy", busy, 0);
    wr_txn(8'h12, 32'h80, 1, 1'b1);

    // Randomized mix of bursts and pointer-set reads
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        wr_txn(8'($urandom), $urandom, int'($urandom_range(1, 4)), 1'b1);
      end else begin
        wr_txn(8'($urandom), 32'h0, 0, 1'($urandom_range(0, 1)));
        rd_txn(int'($urandom_range(1, 3)));
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
